// File: rtl/seq_buffer_pp.sv
// Double-buffered query/database sequence buffer: packs an input word stream into
// two alternating banks so one pair is presented while the next one is loaded.
module seq_buffer_pp #(
   parameter int SEQ_LENGTH   = 32,
   parameter int LETTER_WIDTH = 2,
   parameter int INPUT_WIDTH  = 8
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_flush,
   input  logic                               i_in_valid,
   input  logic [INPUT_WIDTH-1:0]             i_in_data,
   output logic                               o_in_ready,
   output logic                               o_out_valid,
   output logic [SEQ_LENGTH*LETTER_WIDTH-1:0] o_out_query,
   output logic [SEQ_LENGTH*LETTER_WIDTH-1:0] o_out_database,
   output logic                               o_out_bank,
   input  logic                               i_out_release,
   output logic                               o_err_release
);

   localparam int SEQ_BITS = SEQ_LENGTH * LETTER_WIDTH;
   localparam int WORDS    = SEQ_BITS / INPUT_WIDTH;
   localparam int CNT_W    = $clog2(2 * WORDS);

   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(2 * WORDS - 1);

   localparam logic [1:0] BANK_EMPTY   = 2'd0;
   localparam logic [1:0] BANK_FILLING = 2'd1;
   localparam logic [1:0] BANK_FULL    = 2'd2;

   logic [1:0]          r_bank_st  [2];
   logic [SEQ_BITS-1:0] r_query    [2];
   logic [SEQ_BITS-1:0] r_database [2];
   logic                r_wr_bank;
   logic                r_rd_bank;
   logic [CNT_W-1:0]    r_word_cnt;
   logic                r_err_release;

   logic w_clear;
   logic w_in_ready;
   logic w_out_valid;
   logic w_accept;
   logic w_release;
   logic w_last_word;

   assign w_clear     = !i_rst_n || i_flush;
   assign w_in_ready  = (r_bank_st[r_wr_bank] != BANK_FULL);
   assign w_out_valid = (r_bank_st[r_rd_bank] == BANK_FULL);
   assign w_accept    = i_in_valid && w_in_ready;
   assign w_release   = i_out_release && w_out_valid;
   assign w_last_word = w_accept && (r_word_cnt == LAST_WORD);

   // Word w of a pair lands in-place: query for w < WORDS, database otherwise.
   always_ff @(posedge i_clk) begin
      if (w_clear) begin
         for (int unsigned b = 0; b < 2; b++) begin
            r_query[b]    <= '0;
            r_database[b] <= '0;
         end
      end else if (w_accept) begin
         for (int unsigned w = 0; w < WORDS; w++) begin
            if (r_word_cnt == CNT_W'(w))
               r_query[r_wr_bank][w*INPUT_WIDTH +: INPUT_WIDTH] <= i_in_data;
            if (r_word_cnt == CNT_W'(w + WORDS))
               r_database[r_wr_bank][w*INPUT_WIDTH +: INPUT_WIDTH] <= i_in_data;
         end
      end
   end

   // Accept targets a non-FULL bank and release a FULL one, so both may hit
   // different banks on the same edge without conflict.
   always_ff @(posedge i_clk) begin
      if (w_clear) begin
         for (int unsigned b = 0; b < 2; b++)
            r_bank_st[b] <= BANK_EMPTY;
         r_wr_bank     <= 1'b0;
         r_rd_bank     <= 1'b0;
         r_word_cnt    <= '0;
         r_err_release <= 1'b0;
      end else begin
         for (int unsigned b = 0; b < 2; b++) begin
            if (w_accept && (r_wr_bank == 1'(b)))
               r_bank_st[b] <= w_last_word ? BANK_FULL : BANK_FILLING;
            else if (w_release && (r_rd_bank == 1'(b)))
               r_bank_st[b] <= BANK_EMPTY;
         end

         if (w_accept) begin
            if (w_last_word) begin
               r_word_cnt <= '0;
               r_wr_bank  <= ~r_wr_bank;
            end else begin
               r_word_cnt <= r_word_cnt + 1'b1;
            end
         end

         if (w_release)
            r_rd_bank <= ~r_rd_bank;

         if (i_out_release && !w_out_valid)
            r_err_release <= 1'b1;
      end
   end

   assign o_in_ready     = w_in_ready;
   assign o_out_valid    = w_out_valid;
   assign o_out_query    = r_query[r_rd_bank];
   assign o_out_database = r_database[r_rd_bank];
   assign o_out_bank     = r_rd_bank;
   assign o_err_release  = r_err_release;

endmodule

// File: doc/seq_buffer_pp.md
Name: seq_buffer_pp

Overview:
Parametrised, double-buffered (ping-pong) successor to the single-shot sequence buffer. Packs an INPUT_WIDTH-bit byte stream into one query and one database sequence of SEQ_LENGTH letters each. Loads the next sequence pair into the idle bank while the PU array scores the current pair, so there is no reload bubble between alignments. Sits between the host input interface and the PU array / diagonal controller.

Parameters:
SEQ_LENGTH, 32, letters per sequence.
LETTER_WIDTH, 2, bits per letter (A/T/C/G).
INPUT_WIDTH, 8, input word width. INPUT_WIDTH must divide SEQ_LENGTH*LETTER_WIDTH, and LETTER_WIDTH must divide INPUT_WIDTH.
WORDS (derived), SEQ_LENGTH*LETTER_WIDTH/INPUT_WIDTH = 8, words per sequence.
CNT_W (derived), $clog2(2*WORDS) = 4, word counter width.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
flush  in  1  synchronous clear of both banks and all pointers; same effect as reset.
in_valid  in  1  in_data valid.
in_data  in  INPUT_WIDTH  packed letters; letter k of the word occupies bits [k*LETTER_WIDTH +: LETTER_WIDTH].
in_ready  out  1  buffer accepts in_data this cycle.
out_valid  out  1  a full query/database pair is presented.
out_query  out  SEQ_LENGTH*LETTER_WIDTH  query; letter i in bits [i*LETTER_WIDTH +: LETTER_WIDTH].
out_database  out  SEQ_LENGTH*LETTER_WIDTH  database; same packing as out_query.
out_bank  out  1  bank index currently presented.
out_release  in  1  consumer finished with the presented pair.
err_release  out  1  sticky: out_release seen while out_valid=0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset / flush: both banks EMPTY; wr_bank=0, rd_bank=0, word_cnt=0. in_ready=1 from the first cycle after reset. out_valid=0, out_bank=0, err_release=0. out_query and out_database are all-zero.
- Bank state: each bank is EMPTY, FILLING or FULL.
- Transfer: a word is accepted when in_valid && in_ready at a rising edge.
- in_ready: 1 iff bank[wr_bank] != FULL. It is a registered-state function only, with no combinational path from in_valid.
- Fill order: words 0..WORDS-1 go to the query, words WORDS..2*WORDS-1 go to the database. Word w lands at letter offset (w mod WORDS)*(INPUT_WIDTH/LETTER_WIDTH).
- On the first accept into an EMPTY bank, the bank becomes FILLING.
- On the accept with word_cnt==2*WORDS-1: the bank becomes FULL, word_cnt wraps to 0 and wr_bank toggles, all on the same edge.
- Read side: out_valid = (bank[rd_bank]==FULL), registered. If rd_bank is the bank just completed, out_valid rises on the cycle after the last-word edge (latency 1).
- out_query, out_database and out_bank reflect bank rd_bank and are held stable while out_valid=1.
- Release: out_release && out_valid at an edge sets bank[rd_bank] EMPTY and toggles rd_bank. If the other bank is already FULL, out_valid stays 1 and the data switches to the other bank on the next cycle (back-to-back delivery, no bubble).
- Simultaneous events: a last-word accept on one bank and a release of the other bank in the same cycle both take effect.
- Release stall: with both banks FULL, in_ready=0. A release on edge N frees the bank and gives in_ready=1 at cycle N+1; that bank is then refilled.
- Stray release: out_release while out_valid=0 is ignored for state and sets err_release, which clears only on reset or flush.
- Partial data: a FILLING bank is never presented.
- in_valid while in_ready=0: the word is not accepted and the counter does not change. The producer must hold its data.
- flush or reset mid-load or mid-presentation discards all data, including a partially filled bank. There is no partial-output event.
- Storage: two banks of 2*SEQ_LENGTH*LETTER_WIDTH flops each. Writes use in-place indexed part-select; no shifting.

Test Plan:
- Single load (defaults): after reset, 16 accepts with in_data=8'h00..8'h0F. Required: out_valid=1 exactly one cycle after the 16th accept and out_bank=0. out_query[7:0]=8'h00, out_query[63:56]=8'h07, out_database[7:0]=8'h08, out_database[63:56]=8'h0F.
- Ping-pong: load pair A (16 words), then pair B (16 words) with no release. Required: in_ready=1 throughout both loads and drops to 0 after B's last word; out_valid stays 1 showing A. Pulse out_release: the next cycle shows B with out_bank=1, and out_valid never drops. One cycle later, in_ready=1.
- Back-pressure: both banks FULL and in_valid held high with 8'hAA for 5 cycles. Required: in_ready=0 and nothing is accepted. After one release, the word is accepted on the following cycle and lands at query letters 0..3 of bank 0.
- Simultaneous: the 16th word of bank 1 is accepted on the same edge as the release of bank 0. Required: next cycle out_valid=1, out_bank=1, and bank 0 is EMPTY with in_ready=1.
- Stray release and flush: out_release with out_valid=0 gives err_release=1 and no state change. Then load 5 words, assert flush, and load 16 fresh words. Required: the output equals the fresh data only, err_release=0 after flush, and out_bank=0.
- Parameter sweep: SEQ_LENGTH=64, INPUT_WIDTH=16, so WORDS=8. A 16-word load gives out_query letter 63 from bits [15:14] of word 7.
